// File: rtl/game_pkg.sv
// Shared encodings and widths for the game sequencer.
package game_pkg;

  localparam int unsigned SEC_W = 6;
  localparam int unsigned RDY_W = 2;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReady = 3'd1,
    StPlay  = 3'd2,
    StPause = 3'd3,
    StOver  = 3'd4
  } game_state_e;

endpackage

// File: rtl/tick_gen.sv
// Modulo counter with synchronous clear and enable; wrap pulses combinationally on the last count.
module tick_gen #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [Width-1:0] last,
  output logic             wrap
);

  logic [Width-1:0] count_q;

  // >= so that a shortened period takes effect even when the count is already past it
  assign wrap = enable && (count_q >= last);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (wrap) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game sequencer: pre-game countdown, timed play with pause/resume, and mole spawn strobes.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned GAME_SECS  = 60,
  parameter int unsigned READY_SECS = 3,
  parameter int unsigned MOLE_DIV   = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  output logic [2:0]       state,
  output logic [RDY_W-1:0] ready_left,
  output logic [SEC_W-1:0] secs_left,
  output logic             game_active,
  output logic             game_over,
  output logic             mole_tick
);

  localparam int unsigned PreW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MoleW = $clog2(MOLE_DIV);
  localparam logic [SEC_W-1:0] HalfSecs = SEC_W'(GAME_SECS / 2);

  game_state_e state_q;

  logic             sec_tick;
  logic             mole_wrap;
  logic             pre_clear;
  logic             mole_clear;
  logic [MoleW-1:0] mole_last;

  assign state = state_q;

  // Mole period halves once the clock drops to half the game length or below.
  assign mole_last = (secs_left > HalfSecs) ? MoleW'(MOLE_DIV - 1) : MoleW'(MOLE_DIV / 2 - 1);

  always_comb begin
    pre_clear  = 1'b0;
    mole_clear = 1'b0;
    if ((state_q == StIdle || state_q == StOver) && start) begin
      pre_clear = 1'b1;
    end
    if (state_q == StReady && sec_tick && ready_left <= RDY_W'(1)) begin
      pre_clear  = 1'b1;
      mole_clear = 1'b1;
    end
  end

  tick_gen #(
    .Width(PreW)
  ) u_sec_tick (
    .clk   (clk),
    .reset (reset),
    .clear (pre_clear),
    .enable(state_q == StReady || state_q == StPlay),
    .last  (PreW'(TICK_DIV - 1)),
    .wrap  (sec_tick)
  );

  tick_gen #(
    .Width(MoleW)
  ) u_mole_tick (
    .clk   (clk),
    .reset (reset),
    .clear (mole_clear),
    .enable(state_q == StPlay),
    .last  (mole_last),
    .wrap  (mole_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      secs_left   <= SEC_W'(GAME_SECS);
      ready_left  <= '0;
      game_active <= 1'b0;
      game_over   <= 1'b0;
      mole_tick   <= 1'b0;
    end else begin
      game_over <= 1'b0;
      mole_tick <= 1'b0;
      unique case (state_q)
        StIdle, StOver: begin
          if (start) begin
            state_q    <= StReady;
            ready_left <= RDY_W'(READY_SECS);
          end
        end
        StReady: begin
          if (sec_tick) begin
            if (ready_left <= RDY_W'(1)) begin
              state_q     <= StPlay;
              ready_left  <= '0;
              secs_left   <= SEC_W'(GAME_SECS);
              game_active <= 1'b1;
            end else begin
              ready_left <= ready_left - 1'b1;
            end
          end
        end
        StPlay: begin
          // A final tick beats a coincident pause.
          if (sec_tick && secs_left <= SEC_W'(1)) begin
            state_q     <= StOver;
            secs_left   <= '0;
            game_active <= 1'b0;
            game_over   <= 1'b1;
          end else begin
            if (sec_tick) begin
              secs_left <= secs_left - 1'b1;
            end
            if (pause) begin
              state_q     <= StPause;
              game_active <= 1'b0;
            end else begin
              mole_tick <= mole_wrap;
            end
          end
        end
        StPause: begin
          if (pause) begin
            state_q     <= StPlay;
            game_active <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          game_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
